// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memories: word width, NOP encoding, memory
// state and the address-fault check used by both instruction and data memory.
package mips_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic {
    MEM_CLEAR = 1'b0,
    MEM_IDLE  = 1'b1
  } mem_state_t;

  // A byte address faults when it is not word aligned or lies above the array.
  function automatic logic addr_fault(input logic [31:0] addr, input int unsigned addr_width);
    logic [31:0] upper;
    upper = addr >> (addr_width + 32'd2);
    return (addr[1:0] != 2'b00) || (upper != 32'd0);
  endfunction

endpackage

// File: rtl/sp_ram_1r1w.sv
// DEPTH x DATA_WIDTH RAM with one synchronous read port and one write port.
// A read and write to the same word in one cycle returns the old contents.
module sp_ram_1r1w #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // The array itself has no reset; contents are zeroed by the clear sweep.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: zero-fill sweep after reset, then 1-cycle
// registered fetches from the PC and word loads from a program loader.
module instr_mem_loadable
  import mips_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DATA_WIDTH = INSTR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] FAULT_WORD = NOP_WORD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ready,
  input  logic                  fetch_req,
  input  logic [31:0]           fetch_addr,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  fetch_fault,
  input  logic                  load_en,
  input  logic [31:0]           load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ack,
  output logic                  load_err,
  input  logic                  clear_start,
  output logic                  mem_state
);

  mem_state_t            state;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic                  last_fault;

  logic                  clearing;
  logic                  fetch_acc;
  logic                  load_acc;
  logic                  fetch_bad;
  logic                  load_bad;
  logic [ADDR_WIDTH-1:0] fetch_idx;
  logic [ADDR_WIDTH-1:0] load_idx;

  logic                  ram_re;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Handshake: a request is taken on a rising edge where ready && req; the
  // matching fetch_valid / load_ack pulse is high for exactly the next cycle.
  assign clearing  = (state == MEM_CLEAR);
  assign ready     = (state == MEM_IDLE);
  assign mem_state = state;
  assign fetch_acc = ready & fetch_req;
  assign load_acc  = ready & load_en;
  assign fetch_bad = addr_fault(fetch_addr, ADDR_WIDTH);
  assign load_bad  = addr_fault(load_addr, ADDR_WIDTH);
  assign fetch_idx = fetch_addr[ADDR_WIDTH+1:2];
  assign load_idx  = load_addr[ADDR_WIDTH+1:2];

  // Single write port shared between the sweep and the loader.
  assign ram_re    = fetch_acc & ~fetch_bad;
  assign ram_we    = clearing | (load_acc & ~load_bad);
  assign ram_waddr = clearing ? clr_ptr : load_idx;
  assign ram_wdata = clearing ? '0 : load_data;

  sp_ram_1r1w #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .re    (ram_re),
    .raddr (fetch_idx),
    .rdata (ram_rdata),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= MEM_CLEAR;
      clr_ptr     <= '0;
      fetch_valid <= 1'b0;
      load_ack    <= 1'b0;
      load_err    <= 1'b0;
      last_fault  <= 1'b0;
    end else begin
      fetch_valid <= fetch_acc;
      load_ack    <= load_acc;
      load_err    <= load_acc & load_bad;
      if (fetch_acc) begin
        last_fault <= fetch_bad;
      end
      case (state)
        MEM_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (&clr_ptr) begin
            state <= MEM_IDLE;
          end
        end
        MEM_IDLE: begin
          if (clear_start) begin
            state   <= MEM_CLEAR;
            clr_ptr <= '0;
          end
        end
        default: state <= MEM_CLEAR;
      endcase
    end
  end

  // Read data register holds between fetches; a faulted fetch skips the read
  // and the remembered fault selects the substitute word instead.
  assign fetch_data  = last_fault ? FAULT_WORD : ram_rdata;
  assign fetch_fault = fetch_valid & last_fault;

endmodule
